// File: rtl/id_ex_skid.sv
// id_ex_skid: handshaked ID->EX pipeline register with a 2-entry skid buffer.
// The main entry drives the execute-side outputs. The skid entry catches a bundle
// that was accepted while main was stalled, so id_ready_o can come straight from a flop.
// Flush and reset both reload the entries with a NOP bundle.
// The stall counter saturates and is cleared only by reset.
module id_ex_skid #(
  parameter int PC_W     = 32,
  parameter int INST_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int REG_W    = 32,
  parameter int RADDR_W  = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [PC_W-1:0]     id_pc_i,
  input  logic [INST_W-1:0]   id_inst_i,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic [ALUSEL_W-1:0] id_alusel_i,
  input  logic [REG_W-1:0]    id_reg1_i,
  input  logic [REG_W-1:0]    id_reg2_i,
  input  logic [RADDR_W-1:0]  id_wd_i,
  input  logic                id_wreg_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [PC_W-1:0]     ex_pc_o,
  output logic [INST_W-1:0]   ex_inst_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [REG_W-1:0]    ex_reg1_o,
  output logic [REG_W-1:0]    ex_reg2_o,
  output logic [RADDR_W-1:0]  ex_wd_o,
  output logic                ex_wreg_o,
  output logic [1:0]          occupancy_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  // The state encoding is the occupancy count, so occupancy_o is just the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [INST_W-1:0]   inst;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [REG_W-1:0]    reg1;
    logic [REG_W-1:0]    reg2;
    logic [RADDR_W-1:0]  wd;
    logic                wreg;
  } bundle_t;

  // The NOP bundle is all zeros: EXE_NONE, EXE_RES_NONE, and no register write.
  localparam bundle_t NOP_BUNDLE = '0;

  state_e           state_q, state_d;
  bundle_t          main_q, main_d;
  bundle_t          skid_q, skid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] stall_cnt_q;
  bundle_t          id_bundle;
  logic             in_fire;
  logic             out_fire;

  assign id_bundle = '{pc: id_pc_i, inst: id_inst_i, aluop: id_aluop_i,
                       alusel: id_alusel_i, reg1: id_reg1_i, reg2: id_reg2_i,
                       wd: id_wd_i, wreg: id_wreg_i};

  assign ex_valid_o = (state_q != ST_EMPTY);
  assign id_ready_o = ready_q;
  assign in_fire    = id_valid_i & ready_q;
  assign out_fire   = ex_valid_o & ex_ready_i;

  // Next-state logic: advance the occupancy and route the incoming bundle to main or skid.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through the case infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_BUSY;
          main_d  = id_bundle;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = id_bundle;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = id_bundle;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_q is low in FULL, so in_fire cannot occur here.
        if (out_fire) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush overrides both handshakes: the incoming bundle is dropped and the held entries become bubbles.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = NOP_BUNDLE;
      skid_d  = NOP_BUNDLE;
    end
    ready_d = (state_d != ST_FULL);
  end

  // State, storage and the registered ready flag. Reset behaves like a flush.
  always_ff @(posedge clk) begin
    // NOTE: the payload entries are reset as well, because the held values remain visible on ex_* while the stage is empty.
    if (!rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      main_q  <= NOP_BUNDLE;
      skid_q  <= NOP_BUNDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Saturating count of the cycles in which execute back-pressures a valid bundle. Flush does not affect it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (ex_valid_o && !ex_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign ex_pc_o     = main_q.pc;
  assign ex_inst_o   = main_q.inst;
  assign ex_aluop_o  = main_q.aluop;
  assign ex_alusel_o = main_q.alusel;
  assign ex_reg1_o   = main_q.reg1;
  assign ex_reg2_o   = main_q.reg2;
  assign ex_wd_o     = main_q.wd;
  assign ex_wreg_o   = main_q.wreg & ex_valid_o;

endmodule
